fp_align_unit: RTL
==================

# fp_align_unit

Operand-alignment front end of the FP32 adder datapath. Accepts two IEEE-754 single-precision operands and orders them by magnitude. Right-shifts the smaller significand by the exponent difference into the 28-bit extended format {hidden, frac[22:0], guard, round, sticky[1:0]} that the rounding stage consumes at its input. Two-stage valid/ready pipeline sitting between operand capture and the significand adder.

## Interface
Parameters:
- none; all widths come from the shared package.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  operand pair present.
- o_ready  out  1  unit accepts the pair this cycle.
- i_data_a  in  32  operand A (IEEE-754 binary32).
- i_data_b  in  32  operand B.
- o_valid  out  1  aligned result present.
- i_ready  in  1  downstream accepts the result this cycle.
- o_exp  out  8  effective exponent of the larger operand.
- o_man_big  out  28  larger significand, extended, unshifted.
- o_man_small  out  28  smaller significand, extended, aligned, sticky-collapsed.
- o_sign_big, o_sign_small  out  1 each  signs of the ordered operands.
- o_swap  out  1  B had the larger magnitude.
- o_special  out  1  either operand has exp = 0xFF (Inf/NaN); flag only, data still produced.

## Operation
- Unpack, per operand:
  - exp == 0 (zero/subnormal): hidden bit 0, effective exponent 1.
  - Otherwise: hidden bit 1, effective exponent = exp.
  - Extended significand = {hidden, frac, 4'b0000}.
- Order:
  - Swap when {exp_b, frac_b} > {exp_a, frac_a} (unsigned magnitude compare).
  - Equal magnitude: no swap, o_swap = 0.
- Shift amount: d = eff_exp_big − eff_exp_small, 0..254.
- Align:
  - d < 28: man_small = ext_small >> d; bit 0 |= OR of all bits shifted out.
  - d ≥ 28: man_small = {27'b0, |ext_small}.
- o_man_big = ext_big.
- o_exp = eff_exp_big.
- o_special = (exp_a == 0xFF) | (exp_b == 0xFF).
- Stage 1 register: unpack, compare, swap, d (clamped to 28).
- Stage 2 register: shift and sticky collapse; outputs driven directly from stage-2 registers.

## Timing
- Latency: 2 cycles from accepted input (i_valid & o_ready) to o_valid.
- Throughput: 1 pair per cycle while i_ready = 1.
- Enables:
  - en2 = ~v2 | i_ready.
  - en1 = ~v1 | en2.
  - o_ready = en1 (combinational from i_ready; accepted).
- Stage 1 loads when en1.
  - v1 <= i_valid on load.
  - Payload captured only if i_valid.
- Stage 2 loads when en2: v2 <= v1.
- o_valid = v2. Payload is stable while o_valid & ~i_ready.
- No transaction lost or duplicated under any i_ready pattern; order preserved.
- Reset:
  - v1, v2, o_valid clear in the cycle following i_rst high.
  - All data outputs (o_exp, o_man_*, signs, o_swap, o_special) reset to 0.
  - o_ready = 1 out of reset.
  - Reset mid-stream discards in-flight pairs; no output after reset for pre-reset inputs.
- Simultaneous accept and output with both stages full and i_ready = 1: both stages advance, the new pair enters, full rate is sustained.

## Structure
- Shared package fp_pkg:
  - SIZE_EXP = 8, SIZE_FRAC = 23, SIZE_MAN = 28, SIZE_MAN_RESULT = 24.
  - Typedef struct unpacked operand {sign, eff_exp[7:0], man[27:0]}.
  - Typedef struct aligned result matching the output bundle.
- One sub-module: shift_right_sticky (28-bit data, 5-bit clamped shift amount, sticky OR into bit 0), combinational, instantiated in stage 2.

## Test plan
- a=0x3F800000, b=0x3F000000 -> after 2 cycles: o_exp=0x7F, o_man_big=0x8000000, o_man_small=0x4000000, o_swap=0.
- a=0x3F000000, b=0x3F800000 -> same mantissas/exponent, o_swap=1; signs follow the swap (b=0xBF800000 gives o_sign_big=1).
- a=0x4B800000, b=0x3F800001 (d=24) -> o_man_small=0x0000009 (bit 3 from hidden, sticky bit 0 set).
- a=0x4F800000, b=0x3F800000 (d=32) -> o_man_small=0x0000001; a=0x4F800000, b=0x00000000 -> o_man_small=0x0000000.
- Subnormal: a=0x00800000, b=0x00000001 -> o_exp=0x01, o_man_big=0x8000000, o_man_small=0x0000010. a=0x7F800000 -> o_special=1.
- Handshake/reset:
  - Stream 4 pairs with i_ready held low 3 cycles: o_ready drops after 2 accepted, all 4 emerge in order exactly once.
  - i_rst asserted with both stages full: o_valid=0 next cycle, outputs 0, o_ready=1.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the FP32 adder front end.
// Holds operand/result widths, the unpacked operand and aligned-result bundles,
// and the IEEE-754 binary32 unpack helper used by the alignment unit.
package fp_pkg;

    localparam int unsigned SIZE_EXP        = 8;
    localparam int unsigned SIZE_FRAC       = 23;
    localparam int unsigned SIZE_MAN        = 28;
    localparam int unsigned SIZE_MAN_RESULT = 24;
    localparam int unsigned SIZE_SHAMT      = 5;

    // Any shift of SIZE_MAN or more collapses the whole significand into sticky.
    localparam logic [SIZE_SHAMT-1:0] SHAMT_MAX = 5'd28;

    // Extended significand layout: {hidden, frac[22:0], guard, round, sticky[1:0]}.
    typedef struct packed {
        logic                sign;
        logic [SIZE_EXP-1:0] eff_exp;
        logic [SIZE_MAN-1:0] man;
    } operand_t;

    typedef struct packed {
        logic [SIZE_EXP-1:0] exp;
        logic [SIZE_MAN-1:0] man_big;
        logic [SIZE_MAN-1:0] man_small;
        logic                sign_big;
        logic                sign_small;
        logic                swap;
        logic                special;
    } aligned_t;

    // Zero/subnormal operands carry no hidden bit and behave as exponent 1.
    function automatic operand_t unpack_operand(input logic [31:0] i_word);
        operand_t w_op;
        logic     w_hidden;
        w_hidden     = (i_word[30:23] != '0);
        w_op.sign    = i_word[31];
        w_op.eff_exp = w_hidden ? i_word[30:23] : 8'd1;
        w_op.man     = {w_hidden, i_word[22:0], 4'b0000};
        return w_op;
    endfunction

endpackage

// File: rtl/shift_right_sticky.sv
// Combinational right shifter with sticky collapse.
// Ports:
//   i_data  [27:0] extended significand to shift
//   i_shamt [4:0]  shift amount, already clamped to 0..28
//   o_data  [27:0] shifted significand; bit 0 ORed with every bit shifted out
module shift_right_sticky
    import fp_pkg::*;
(
    input  logic [SIZE_MAN-1:0]   i_data,
    input  logic [SIZE_SHAMT-1:0] i_shamt,
    output logic [SIZE_MAN-1:0]   o_data
);

    logic [SIZE_MAN-1:0] w_shifted;
    logic [SIZE_MAN-1:0] w_lost_mask;
    logic                w_sticky;

    always_comb begin
        w_shifted   = i_data >> i_shamt;
        // Ones in the positions that fall off the bottom of the shift.
        w_lost_mask = ~({SIZE_MAN{1'b1}} << i_shamt);
        w_sticky    = |(i_data & w_lost_mask);
        if (i_shamt >= SHAMT_MAX) begin
            o_data = {{(SIZE_MAN-1){1'b0}}, |i_data};
        end else begin
            o_data = {w_shifted[SIZE_MAN-1:1], w_shifted[0] | w_sticky};
        end
    end

endmodule

// File: rtl/fp_align_unit.sv
// FP32 adder operand-alignment front end.
// Orders two binary32 operands by magnitude and right-shifts the smaller
// significand (with sticky collapse) to the larger operand's exponent.
// Two-stage valid/ready pipeline: stage 1 unpacks/compares/swaps, stage 2 aligns.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_valid, o_ready             input handshake
//   i_data_a, i_data_b [31:0]    operands
//   o_valid, i_ready             output handshake
//   o_exp [7:0]                  effective exponent of larger operand
//   o_man_big, o_man_small [27:0] extended significands (small one aligned)
//   o_sign_big, o_sign_small     signs of the ordered operands
//   o_swap                       B had the larger magnitude
//   o_special                    either exponent field is all ones
module fp_align_unit
    import fp_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [31:0]         i_data_a,
    input  logic [31:0]         i_data_b,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [SIZE_EXP-1:0] o_exp,
    output logic [SIZE_MAN-1:0] o_man_big,
    output logic [SIZE_MAN-1:0] o_man_small,
    output logic                o_sign_big,
    output logic                o_sign_small,
    output logic                o_swap,
    output logic                o_special
);

    // Handshake enables
    logic w_en1;
    logic w_en2;

    // Stage-1 combinational front end
    operand_t              w_op_a;
    operand_t              w_op_b;
    operand_t              w_big;
    operand_t              w_small;
    logic                  w_swap;
    logic                  w_special;
    logic [SIZE_EXP-1:0]   w_diff;
    logic [SIZE_SHAMT-1:0] w_shamt;

    // Stage-1 registers
    logic                  r_v1;
    operand_t              r_s1_big;
    operand_t              r_s1_small;
    logic [SIZE_SHAMT-1:0] r_s1_shamt;
    logic                  r_s1_swap;
    logic                  r_s1_special;

    // Stage-2 registers
    logic                  r_v2;
    aligned_t              r_out;
    logic [SIZE_MAN-1:0]   w_man_aligned;

    assign w_en2   = ~r_v2 | i_ready;
    assign w_en1   = ~r_v1 | w_en2;
    assign o_ready = w_en1;

    always_comb begin
        w_op_a    = unpack_operand(i_data_a);
        w_op_b    = unpack_operand(i_data_b);
        // Exponent and fraction are contiguous, so this compares magnitudes.
        w_swap    = i_data_b[30:0] > i_data_a[30:0];
        w_big     = w_swap ? w_op_b : w_op_a;
        w_small   = w_swap ? w_op_a : w_op_b;
        w_special = (i_data_a[30:23] == 8'hFF) | (i_data_b[30:23] == 8'hFF);
        w_diff    = w_big.eff_exp - w_small.eff_exp;
        w_shamt   = (w_diff >= 8'(SIZE_MAN)) ? SHAMT_MAX : w_diff[SIZE_SHAMT-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v1         <= 1'b0;
            r_s1_big     <= '0;
            r_s1_small   <= '0;
            r_s1_shamt   <= '0;
            r_s1_swap    <= 1'b0;
            r_s1_special <= 1'b0;
        end else if (w_en1) begin
            r_v1 <= i_valid;
            if (i_valid) begin
                r_s1_big     <= w_big;
                r_s1_small   <= w_small;
                r_s1_shamt   <= w_shamt;
                r_s1_swap    <= w_swap;
                r_s1_special <= w_special;
            end
        end
    end

    shift_right_sticky u_shift (
        .i_data  (r_s1_small.man),
        .i_shamt (r_s1_shamt),
        .o_data  (w_man_aligned)
    );

    // Payload only moves with a valid item so held outputs never change under backpressure.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v2  <= 1'b0;
            r_out <= '0;
        end else if (w_en2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_out.exp        <= r_s1_big.eff_exp;
                r_out.man_big    <= r_s1_big.man;
                r_out.man_small  <= w_man_aligned;
                r_out.sign_big   <= r_s1_big.sign;
                r_out.sign_small <= r_s1_small.sign;
                r_out.swap       <= r_s1_swap;
                r_out.special    <= r_s1_special;
            end
        end
    end

    assign o_valid      = r_v2;
    assign o_exp        = r_out.exp;
    assign o_man_big    = r_out.man_big;
    assign o_man_small  = r_out.man_small;
    assign o_sign_big   = r_out.sign_big;
    assign o_sign_small = r_out.sign_small;
    assign o_swap       = r_out.swap;
    assign o_special    = r_out.special;

endmodule
